// File: rtl/avg_decim_fifo.sv
// Keeps every DECIM-th sample from the moving-average filter and buffers the kept samples in a
// DEPTH-entry FIFO drained over valid/ready; overflow raises a sticky flag and counts the drops.
module avg_decim_fifo #(
  parameter int WIDTH = 16,
  parameter int DECIM = 4,
  parameter int DEPTH = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      clr,
  input  logic                      in_valid,
  input  logic signed [WIDTH-1:0]   in_sample,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic signed [WIDTH-1:0]   out_sample,
  output logic [$clog2(DEPTH):0]    level,
  output logic                      overflow,
  output logic [7:0]                drop_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam int PW = (DECIM > 1) ? $clog2(DECIM) : 1;
  localparam logic [PW-1:0] LAST_PHASE = PW'(DECIM - 1);

  logic signed [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [PW-1:0] phase;

  logic keep, full, pop, push, drop;

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  always_comb begin
    keep = in_valid && (phase == LAST_PHASE);
    full = (level == LW'(DEPTH));
    pop  = (level != '0) && out_ready;
    // A full FIFO still accepts a kept sample when the head leaves on the same edge.
    push = keep && (!full || pop);
    drop = keep && full && !pop;
  end

  assign out_valid  = (level != '0);
  assign out_sample = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      phase    <= '0;
      level    <= '0;
      overflow <= 1'b0;
      drop_cnt <= '0;
    end else if (clr) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      phase    <= '0;
      level    <= '0;
      overflow <= 1'b0;
      drop_cnt <= '0;
    end else begin
      if (in_valid) phase <= (phase == LAST_PHASE) ? '0 : phase + 1'b1;
      if (push) begin
        mem[wr_ptr] <= in_sample;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
      if (drop) begin
        overflow <= 1'b1;
        drop_cnt <= sat_inc(drop_cnt);
      end
    end
  end

endmodule

// File: tb/tb_avg_decim_fifo.sv
// Directed bench: instance a runs DECIM=4, instance b runs DECIM=1, both with DEPTH=8.
module tb_avg_decim_fifo;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic               clr_a = 1'b0, iv_a = 1'b0, or_a = 1'b0;
  logic signed [15:0] is_a = '0;
  logic               ov_a, of_a;
  logic signed [15:0] os_a;
  logic [3:0]         lv_a;
  logic [7:0]         dc_a;

  logic               clr_b = 1'b0, iv_b = 1'b0, or_b = 1'b0;
  logic signed [15:0] is_b = '0;
  logic               ov_b, of_b;
  logic signed [15:0] os_b;
  logic [3:0]         lv_b;
  logic [7:0]         dc_b;

  int total = 0;
  int bad = 0;

  avg_decim_fifo #(.WIDTH(16), .DECIM(4), .DEPTH(8)) u_a (
    .clk(clk), .rst_n(rst_n), .clr(clr_a), .in_valid(iv_a), .in_sample(is_a),
    .out_valid(ov_a), .out_ready(or_a), .out_sample(os_a), .level(lv_a),
    .overflow(of_a), .drop_cnt(dc_a)
  );

  avg_decim_fifo #(.WIDTH(16), .DECIM(1), .DEPTH(8)) u_b (
    .clk(clk), .rst_n(rst_n), .clr(clr_b), .in_valid(iv_b), .in_sample(is_b),
    .out_valid(ov_b), .out_ready(or_b), .out_sample(os_b), .level(lv_b),
    .overflow(of_b), .drop_cnt(dc_b)
  );

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [15:0] pat [3];
  int vi;
  int exp_i;

  initial begin
    pat[0] = 16'h8000; pat[1] = 16'h7FFF; pat[2] = 16'hFFFF;

    // reset state
    step(); step();
    chk("rst_ov_a", 16'(ov_a), 16'd0);
    chk("rst_lv_a", 16'(lv_a), 16'd0);
    chk("rst_of_a", 16'(of_a), 16'd0);
    chk("rst_dc_a", 16'(dc_a), 16'd0);
    chk("rst_os_a", os_a, 16'd0);
    chk("rst_ov_b", 16'(ov_b), 16'd0);
    rst_n = 1'b1;
    step();

    // decimation by 4, free-running consumer
    or_a = 1'b1;
    for (int i = 1; i <= 12; i++) begin
      iv_a = 1'b1; is_a = 16'(i);
      step();
      chk("dec_ov", 16'(ov_a), (i % 4 == 0) ? 16'd1 : 16'd0);
      chk("dec_lv", 16'(lv_a), (i % 4 == 0) ? 16'd1 : 16'd0);
      if (i % 4 == 0) chk("dec_os", os_a, 16'(i));
    end
    iv_a = 1'b0;
    step();
    chk("dec_drain_lv", 16'(lv_a), 16'd0);

    // clear priority: three buffered entries, phase 2, then clr with in_valid
    or_a = 1'b0;
    for (int i = 21; i <= 34; i++) begin
      iv_a = 1'b1; is_a = 16'(i);
      step();
    end
    chk("clrpre_lv", 16'(lv_a), 16'd3);
    chk("clrpre_os", os_a, 16'd24);
    clr_a = 1'b1; is_a = 16'd35;
    step();
    clr_a = 1'b0;
    chk("clr_lv", 16'(lv_a), 16'd0);
    chk("clr_ov", 16'(ov_a), 16'd0);
    chk("clr_of", 16'(of_a), 16'd0);
    for (int i = 41; i <= 44; i++) begin
      is_a = 16'(i);
      step();
      chk("clrpost_lv", 16'(lv_a), (i == 44) ? 16'd1 : 16'd0);
    end
    iv_a = 1'b0;
    chk("clrpost_os", os_a, 16'd44);

    // fill, overflow and drain (DECIM=1)
    or_b = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      iv_b = 1'b1; is_b = 16'(-i);
      step();
    end
    iv_b = 1'b0;
    chk("ovf_lv", 16'(lv_b), 16'd8);
    chk("ovf_of", 16'(of_b), 16'd1);
    chk("ovf_dc", 16'(dc_b), 16'd2);
    or_b = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      chk("drain_ov", 16'(ov_b), 16'd1);
      chk("drain_os", os_b, 16'(-k));
      step();
    end
    chk("drain_empty", 16'(ov_b), 16'd0);
    chk("drain_of_sticky", 16'(of_b), 16'd1);

    // clr clears the sticky flag and counter
    clr_b = 1'b1;
    step();
    clr_b = 1'b0;
    chk("clrb_of", 16'(of_b), 16'd0);
    chk("clrb_dc", 16'(dc_b), 16'd0);

    // full with simultaneous push and pop
    or_b = 1'b0;
    for (int i = 100; i <= 107; i++) begin
      iv_b = 1'b1; is_b = 16'(i);
      step();
    end
    iv_b = 1'b0;
    chk("full_lv", 16'(lv_b), 16'd8);
    chk("full_head", os_b, 16'd100);
    or_b = 1'b1; iv_b = 1'b1; is_b = 16'd108;
    step();
    iv_b = 1'b0;
    chk("pp_lv", 16'(lv_b), 16'd8);
    chk("pp_of", 16'(of_b), 16'd0);
    for (int k = 101; k <= 108; k++) begin
      chk("pp_os", os_b, 16'(k));
      step();
    end
    chk("pp_empty", 16'(ov_b), 16'd0);

    // pointer wrap and sign: alternate full and empty
    vi = 0; exp_i = 0;
    for (int r = 0; r < 3; r++) begin
      or_b = 1'b0;
      for (int k = 0; k < 8; k++) begin
        iv_b = 1'b1; is_b = pat[vi % 3]; vi++;
        step();
      end
      iv_b = 1'b0;
      chk("wrap_full", 16'(lv_b), 16'd8);
      or_b = 1'b1;
      for (int k = 0; k < 8; k++) begin
        chk("wrap_os", os_b, pat[exp_i % 3]); exp_i++;
        step();
      end
      chk("wrap_empty", 16'(ov_b), 16'd0);
    end

    // asynchronous reset with level 5 and drop_cnt 3
    or_b = 1'b0;
    for (int i = 0; i < 11; i++) begin
      iv_b = 1'b1; is_b = 16'(200 + i);
      step();
    end
    iv_b = 1'b0; or_b = 1'b1;
    step(); step(); step();
    or_b = 1'b0;
    chk("ar_pre_lv", 16'(lv_b), 16'd5);
    chk("ar_pre_dc", 16'(dc_b), 16'd3);
    chk("ar_pre_os", os_b, 16'd203);
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_ov", 16'(ov_b), 16'd0);
    chk("ar_lv", 16'(lv_b), 16'd0);
    chk("ar_of", 16'(of_b), 16'd0);
    chk("ar_dc", 16'(dc_b), 16'd0);
    chk("ar_os", os_b, 16'd0);
    step();
    rst_n = 1'b1;
    step();
    chk("ar_post_lv", 16'(lv_b), 16'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
